mem_arbiter: RTL and testbench

//  Sole owner of the byte-wide RAM port. Shares it between the instruction-fetch requester
//  (4-byte reads) and the MEM-stage requester (1/2/4-byte loads and stores).

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_byte_asm.sv | 39 +++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM port arbiter: FSM states,
// access size codes, busy-bit positions and a beat-count helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int BUSY_ANY = 0;
    localparam int BUSY_MEM = 1;

    localparam int BYTES_PER_WORD = 4;

    // Index of the final beat for a size code; code 3 behaves like a word.
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_asm.sv
// mem_byte_assembler: collects read bytes into a little-endian word.
// Each lane has its own write enable; the whole word clears when a new
// access is accepted, so short loads come out zero-extended.
module mem_byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_we,
    input  logic [1:0]  i_lane,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word_next
);

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            logic       w_lane_we;
            logic [7:0] w_lane_next;
            logic [7:0] r_lane;

            assign w_lane_we   = i_we && (i_lane == 2'(gi));
            assign w_lane_next = i_clear   ? 8'h00 :
                                 w_lane_we ? i_byte : r_lane;
            assign o_word_next[8*gi +: 8] = w_lane_next;

            // Lane register: cleared on accept, loaded when its byte arrives.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_lane <= 8'h00;
                end else begin
                    r_lane <= w_lane_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide RAM port, shared between the
// instruction-fetch requester (word reads) and the MEM stage (1/2/4-byte
// loads and stores). MEM wins ties; arbitration only happens in IDLE.
// Optional build macro IO_BUF_STALL_EN adds io_buffer_full_in, which holds
// write beats aimed at the IO region (addr[17:16] == IO_HI).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              if_read_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_load_done_out,
    output logic [31:0]       if_data_out,
    input  logic              mem_req_in,
    input  logic              mem_wr_in,
    input  logic [1:0]        mem_size_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [31:0]       mem_wdata_in,
    output logic              mem_done_out,
    output logic [31:0]       mem_rdata_out,
    output logic [1:0]        busy_state_out,
    input  logic [7:0]        ram_din_in,
    output logic [7:0]        ram_dout_out,
    output logic [ADDR_W-1:0] ram_a_out,
    output logic              ram_wr_out
`ifdef IO_BUF_STALL_EN
    ,
    input  logic              io_buffer_full_in
`endif
);

    state_t            r_state;
    logic              r_req_mem;
    logic              r_drain;
    logic              r_wr;
    logic              r_rd_pend;
    logic [1:0]        r_beat;
    logic [1:0]        r_last;
    logic [1:0]        r_rd_idx;
    logic [1:0]        r_busy_state;
    logic [ADDR_W-1:0] r_ram_a;
    logic [7:0]        r_ram_dout;
    logic [31:0]       r_wdata;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;

    logic              w_accept_mem;
    logic              w_accept_if;
    logic              w_accept;
    logic              w_io_full;
    logic              w_stall;
    logic [1:0]        w_next_beat;
    logic [31:0]       w_word_next;

`ifdef IO_BUF_STALL_EN
    assign w_io_full = io_buffer_full_in;
`else
    assign w_io_full = 1'b0;
`endif

    assign w_accept_mem = (r_state == ST_IDLE) && mem_req_in;
    assign w_accept_if  = (r_state == ST_IDLE) && !mem_req_in && if_read_in;
    assign w_accept     = w_accept_mem || w_accept_if;
    // A held IO write keeps its address/data on the bus but not the strobe.
    assign w_stall      = w_io_full && (r_ram_a[17:16] == IO_HI);
    assign w_next_beat  = r_beat + 2'd1;

    // Main FSM plus the address/data beat registers driving the RAM port.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_IDLE;
            r_req_mem    <= 1'b0;
            r_drain      <= 1'b0;
            r_wr         <= 1'b0;
            r_beat       <= 2'd0;
            r_last       <= 2'd0;
            r_busy_state <= 2'b00;
            r_ram_a      <= '0;
            r_ram_dout   <= 8'h00;
            r_wdata      <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_mem              <= w_accept_mem;
                        r_ram_a                <= w_accept_mem ? mem_addr_in : if_addr_in;
                        r_last                 <= w_accept_mem ? last_beat(mem_size_in) : last_beat(SZ_W);
                        r_wdata                <= mem_wdata_in;
                        r_beat                 <= 2'd0;
                        r_drain                <= 1'b0;
                        r_busy_state[BUSY_ANY] <= 1'b1;
                        r_busy_state[BUSY_MEM] <= w_accept_mem;
                        if (w_accept_mem && mem_wr_in) begin
                            r_state    <= ST_WR;
                            r_wr       <= 1'b1;
                            r_ram_dout <= mem_wdata_in[7:0];
                        end else begin
                            r_state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (!r_drain) begin
                        if (r_beat == r_last) begin
                            r_drain <= 1'b1;
                        end else begin
                            r_beat  <= w_next_beat;
                            r_ram_a <= r_ram_a + ADDR_W'(1);
                        end
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_WR: begin
                    if (!w_stall) begin
                        if (r_beat == r_last) begin
                            r_wr    <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_beat     <= w_next_beat;
                            r_ram_a    <= r_ram_a + ADDR_W'(1);
                            r_ram_dout <= r_wdata[{w_next_beat, 3'b000} +: 8];
                        end
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_busy_state <= 2'b00;
                end
            endcase
        end
    end

    // Read pipeline: remember which lane the RAM byte arriving next cycle belongs to.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_pend <= 1'b0;
            r_rd_idx  <= 2'd0;
        end else begin
            r_rd_pend <= (r_state == ST_RD) && !r_drain;
            r_rd_idx  <= r_beat;
        end
    end

    mem_byte_assembler u_asm (
        .i_clk       (clk_in),
        .i_rst_n     (rst_n_in),
        .i_clear     (w_accept),
        .i_we        (r_rd_pend),
        .i_lane      (r_rd_idx),
        .i_byte      (ram_din_in),
        .o_word_next (w_word_next)
    );

    // Result registers: loaded as the last byte lands so data is valid with done, then held.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_if_data   <= 32'h0;
            r_mem_rdata <= 32'h0;
        end else if ((r_state == ST_RD) && r_drain) begin
            if (r_req_mem) begin
                r_mem_rdata <= w_word_next;
            end else begin
                r_if_data   <= w_word_next;
            end
        end
    end

    assign if_load_done_out = (r_state == ST_DONE) && !r_req_mem;
    assign mem_done_out     = (r_state == ST_DONE) &&  r_req_mem;
    assign if_data_out      = r_if_data;
    assign mem_rdata_out    = r_mem_rdata;
    assign busy_state_out   = r_busy_state;
    assign ram_a_out        = r_ram_a;
    assign ram_dout_out     = r_ram_dout;
    assign ram_wr_out       = r_wr && !w_stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver issues accesses and pushes
// expected results; a separate monitor checks each done pulse and each
// RAM write beat. The RAM is a 4 KiB array indexed by the low address bits.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_read = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_wr = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [1:0]  busy;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
`ifdef IO_BUF_STALL_EN
    logic        io_full = 1'b0;
`endif

    typedef struct {
        logic        is_load;
        logic [31:0] addr;
        logic [31:0] data;
        int          start;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wexp_t;

    exp_t  if_q[$];
    exp_t  mem_q[$];
    wexp_t wr_q[$];

    logic [7:0]  ram [0:4095];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_if = 32'h0;
    logic [31:0] last_mem = 32'h0;

    mem_arbiter dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .if_read_in       (if_read),
        .if_addr_in       (if_addr),
        .if_load_done_out (if_done),
        .if_data_out      (if_data),
        .mem_req_in       (mem_req),
        .mem_wr_in        (mem_wr),
        .mem_size_in      (mem_size),
        .mem_addr_in      (mem_addr),
        .mem_wdata_in     (mem_wdata),
        .mem_done_out     (mem_done),
        .mem_rdata_out    (mem_rdata),
        .busy_state_out   (busy),
        .ram_din_in       (ram_din),
        .ram_dout_out     (ram_dout),
        .ram_a_out        (ram_a),
        .ram_wr_out       (ram_wr)
`ifdef IO_BUF_STALL_EN
        ,
        .io_buffer_full_in(io_full)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte RAM: data appears one cycle after its address.
    always @(posedge clk) begin
        if (rst_n && ram_wr) ram[ram_a[11:0]] <= ram_dout;
        ram_din <= ram[ram_a[11:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbeats(input logic [1:0] size);
        if (size == SZ_B) return 1;
        if (size == SZ_H) return 2;
        return 4;
    endfunction

    // Little-endian read of n bytes, address wrapping modulo 2^32.
    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] r;
        logic [31:0] a;
        r = 32'h0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            r[8*k +: 8] = ram[a[11:0]];
        end
        return r;
    endfunction

    task automatic issue_mem(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input int stall);
        int    n;
        exp_t  e;
        wexp_t w;
        n = nbeats(size);
        e.is_load = !wr;
        e.addr    = addr;
        e.start   = cyc;
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                w.a = addr + 32'(k);
                w.d = 8'(wdata >> (8*k));
                wr_q.push_back(w);
            end
            e.data = 32'h0;
            e.lat  = n + 1 + stall;
        end else begin
            e.data = ref_read(addr, n);
            e.lat  = n + 2;
        end
        mem_q.push_back(e);
        mem_req   = 1'b1;
        mem_wr    = wr;
        mem_size  = size;
        mem_addr  = addr;
        mem_wdata = wdata;
    endtask

    task automatic issue_if(input logic [31:0] addr, input int start);
        exp_t e;
        e.is_load = 1'b1;
        e.addr    = addr;
        e.data    = ref_read(addr, 4);
        e.start   = start;
        e.lat     = 6;
        if_q.push_back(e);
        if_read = 1'b1;
        if_addr = addr;
    endtask

    // Waits for the requester's done, checking busy every cycle; drops the request in the done cycle.
    task automatic wait_done(input bit is_mem, input int start);
        bit          seen;
        int          d;
        logic [31:0] exp_busy;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            d = cyc - start;
            exp_busy = (d <= 0) ? 32'd0 : (is_mem ? 32'd3 : 32'd1);
            if (is_mem) chk("busy_mem", 32'(busy), exp_busy);
            else        chk("busy_if", 32'(busy), exp_busy);
            seen = is_mem ? mem_done : if_done;
        end
        if (!seen) begin
            if (is_mem) chk("mem_done_timeout", 32'd0, 32'd1);
            else        chk("if_done_timeout", 32'd0, 32'd1);
        end
        if (is_mem) mem_req = 1'b0;
        else        if_read = 1'b0;
    endtask

    // Monitor: compares every done pulse and every RAM write beat with the queues.
    initial begin : monitor
        exp_t  e;
        wexp_t w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_if  = 32'h0;
                last_mem = 32'h0;
            end else begin
                if (if_done) begin
                    if (if_q.size() == 0) begin
                        chk("if_done_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = if_q.pop_front();
                        chk("if_data", if_data, e.data);
                        chk("if_latency", 32'(cyc - e.start), 32'(e.lat));
                        chk("if_keeps_mem_rdata", mem_rdata, last_mem);
                        last_if = e.data;
                        $display("[TB] IF  read  addr=%08h data=%08h cycle=%0d", e.addr, if_data, cyc);
                    end
                end
                if (mem_done) begin
                    if (mem_q.size() == 0) begin
                        chk("mem_done_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = mem_q.pop_front();
                        if (e.is_load) begin
                            chk("mem_rdata", mem_rdata, e.data);
                            last_mem = e.data;
                        end else begin
                            chk("mem_rdata_hold", mem_rdata, last_mem);
                        end
                        chk("mem_latency", 32'(cyc - e.start), 32'(e.lat));
                        chk("mem_keeps_if_data", if_data, last_if);
                        $display("[TB] MEM %s addr=%08h rdata=%08h cycle=%0d",
                                 e.is_load ? "load " : "store", e.addr, mem_rdata, cyc);
                    end
                end
                if (ram_wr) begin
                    if (wr_q.size() == 0) begin
                        chk("ram_wr_unexpected", 32'd1, 32'd0);
                    end else begin
                        w = wr_q.pop_front();
                        chk("ram_wr_addr", ram_a, w.a);
                        chk("ram_wr_data", 32'(ram_dout), 32'(w.d));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] a;
        logic [31:0] a_if;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          st;
        int          st2;
        int          mode;

        for (int i = 0; i < 4096; i++) ram[i] <= 8'($urandom);
        ram[12'h100] <= 8'h11;
        ram[12'h101] <= 8'h22;
        ram[12'h102] <= 8'h33;
        ram[12'h103] <= 8'h44;

        // Reset held with a fetch request pending: every output must be 0.
        rst_n   = 1'b0;
        if_read = 1'b1;
        if_addr = 32'h0000_0100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_done",   32'(if_done),   32'd0);
        chk("rst_if_data",   if_data,        32'd0);
        chk("rst_mem_done",  32'(mem_done),  32'd0);
        chk("rst_mem_rdata", mem_rdata,      32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_ram_a",     ram_a,          32'd0);
        chk("rst_ram_dout",  32'(ram_dout),  32'd0);
        chk("rst_ram_wr",    32'(ram_wr),    32'd0);

        // Release: the pending fetch is taken in the first IDLE cycle; expects 0x44332211 in cycle 6.
        @(posedge clk); #1;
        rst_n = 1'b1;
        st = cyc;
        issue_if(32'h0000_0100, st);
        chk("ref_word_0x100", if_q[0].data, 32'h4433_2211);
        wait_done(1'b0, st);

        // Simultaneous IF and MEM byte store: MEM first, IF afterwards.
        @(posedge clk); #1;
        st = cyc;
        a_if = $urandom;
        issue_mem(1'b1, SZ_B, 32'h0000_0200, 32'h0000_00AB, 0);
        if_read = 1'b1;
        if_addr = a_if;
        wait_done(1'b1, st);
        st2 = cyc + 1;
        issue_if(a_if, st2);
        wait_done(1'b0, st2);

        // Half load across the top of the address space.
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        ram[12'hFFF] <= b0;
        ram[12'h000] <= b1;
        @(posedge clk); #1;
        st = cyc;
        issue_mem(1'b0, SZ_H, 32'hFFFF_FFFF, 32'h0, 0);
        chk("ref_half_wrap", mem_q[0].data, {16'h0, b1, b0});
        wait_done(1'b1, st);

        // Reset pulse during beat 2 of a word store: two beats land, nothing else.
        @(posedge clk); #1;
        a = $urandom;
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_size  = SZ_W;
        mem_addr  = a;
        mem_wdata = $urandom;
        for (int k = 0; k < 2; k++) begin
            wexp_t w;
            w.a = a + 32'(k);
            w.d = 8'(mem_wdata >> (8*k));
            wr_q.push_back(w);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("abort_ram_wr", 32'(ram_wr), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_idle_busy", 32'(busy), 32'd0);
        end
        chk("abort_wr_q_empty", 32'(wr_q.size()), 32'd0);

`ifdef IO_BUF_STALL_EN
        // IO store held for three cycles by a full IO buffer.
        @(posedge clk); #1;
        st = cyc;
        io_full = 1'b1;
        issue_mem(1'b1, SZ_B, 32'h0003_0000, $urandom, 3);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_ram_wr_low", 32'(ram_wr), 32'd0);
        end
        @(posedge clk); #1;
        io_full = 1'b0;
        wait_done(1'b1, st);
`endif

        // Randomized traffic: IF only, MEM only, or both in the same cycle.
        for (int t = 0; t < 150; t++) begin
            mode = $urandom_range(0, 2);
            a    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
            a_if = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFD + 32'($urandom_range(0, 2))) : $urandom;
            @(posedge clk); #1;
            st = cyc;
            if (mode == 0) begin
                issue_if(a_if, st);
                wait_done(1'b0, st);
            end else begin
                issue_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, 0);
                if (mode == 2) begin
                    if_read = 1'b1;
                    if_addr = a_if;
                end
                wait_done(1'b1, st);
                if (mode == 2) begin
                    st2 = cyc + 1;
                    issue_if(a_if, st2);
                    wait_done(1'b0, st2);
                end
            end
        end

        repeat (5) @(negedge clk);
        chk("if_q_drained",  32'(if_q.size()),  32'd0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        chk("wr_q_drained",  32'(wr_q.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
